// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the async FIFO read-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Widest request vector the search function handles; callers zero-extend.
    localparam int ARB_MAX_REQ = 32;
    localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

    // First set bit of req[n-1:0] searching upward from last+1 with wrap.
    // Returns 0 when no bit is set; callers qualify with |req.
    function automatic int rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                   input int n,
                                   input int last);
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int i = 1; i <= ARB_MAX_REQ; i++) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[ARB_IDX_W-1:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin priority encoder: next requester after 'last'.
module rr_pick_next
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      pick,
    output logic               any
);

    logic [ARB_MAX_REQ-1:0] req_ext;

    // Widen the request vector and run the wrap-around search.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = IW'(rr_pick(req_ext, NUM_REQ, int'(last)));
        any                    = |req;
    end

endmodule

// File: rtl/rptr_rd_arbiter.sv
// Read-side scheduler sharing one async FIFO read port between NUM_REQ
// consumers. Grants round-robin bursts of up to MAX_BURST words, pops only
// when the single output slot can take the word, and tags each word one-hot
// with the consumer that was granted when it was popped.
module rptr_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DSIZE     = 8,
    parameter  int MAX_BURST = 4,
    localparam int CNTW      = $clog2(MAX_BURST + 1),
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic               rempty,
    input  logic [DSIZE-1:0]   rdata,
    output logic               rinc,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] out_valid,
    output logic [DSIZE-1:0]   out_data,
    input  logic [NUM_REQ-1:0] out_ready,
    output logic               busy
);

    arb_state_e      state;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   last;
    logic [CNTW-1:0] burst_cnt;

    logic [IW-1:0]   pick;
    logic            pick_any;
    logic            drain;
    logic            slot_free;
    logic            cnt_below;
    logic [CNTW-1:0] cnt_next;
    logic            burst_done;

    rr_pick_next #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (pick_any)
    );

    // A pop and a drain of the slot may happen in the same cycle.
    assign drain      = |(out_valid & out_ready);
    assign slot_free  = (out_valid == '0) || drain;
    assign cnt_below  = burst_cnt < CNTW'(MAX_BURST);
    assign rinc       = (state == ARB_BURST) && !rempty && req[gidx] && slot_free && cnt_below;
    assign cnt_next   = burst_cnt + CNTW'(rinc);
    // Burst ends on a full count, a dropped request, or an empty FIFO with no pop.
    assign burst_done = (cnt_next == CNTW'(MAX_BURST)) || !req[gidx] || (rempty && !rinc);
    assign busy       = (state == ARB_BURST) || (out_valid != '0);

    // Grant FSM: arbitrate in IDLE, hold the grant for one burst in BURST.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            gidx      <= '0;
            last      <= IW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_any && !rempty) begin
                state     <= ARB_BURST;
                grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                gidx      <= pick;
                last      <= pick;
                burst_cnt <= '0;
            end
        end else begin
            burst_cnt <= cnt_next;
            if (burst_done) begin
                state <= ARB_IDLE;
                grant <= '0;
            end
        end
    end

    // Output slot: load on pop (owner = current grant), clear on drain.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else if (rinc) begin
            out_valid <= grant;
            out_data  <= rdata;
        end else if (drain) begin
            out_valid <= '0;
        end
    end

endmodule
